vram_arbiter: RTL and testbench

- Single-port owner of the shared video/system RAM (sync BRAM, 1-cycle read latency).
- Arbitrates three requesters: video fetch (char/attr/row reads), CPU (read/write), loader (write-only ROM/cart image load).
- Video has absolute priority; CPU and loader share the remaining slots round-robin.
- Sits between the video generator, CPU bus glue and loader, directly in front of the RAM macro.

---
 rtl/vram_arb_pkg.sv | 18 +
 rtl/vram_rr_pick.sv | 14 +
 rtl/vram_arbiter.sv | 132 +++++++++++++
 tb/tb_vram_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and defaults for the VRAM arbiter.
package vram_arb_pkg;

    // Owner of a RAM slot; OWN_LDR is only used as the round-robin marker
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_LDR  = 2'd3
    } owner_t;

    localparam int          AW_DEF       = 16;
    localparam int          DW_DEF       = 8;
    localparam logic [15:0] ROM_BASE_DEF = 16'h8000;
    localparam logic [15:0] ROM_TOP_DEF  = 16'h8FFF;
    localparam int          MAX_WAIT_DEF = 15;

endpackage

// File: rtl/vram_rr_pick.sv
// 2-way round-robin picker. req[0]=CPU, req[1]=loader.
// last=1 means the loader won the previous shared slot, so the CPU wins a tie.
// The last-winner state is held by the parent.
module vram_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt
);

    assign gnt[0] = en & req[0] & (~req[1] |  last);
    assign gnt[1] = en & req[1] & (~req[0] | ~last);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port owner of the shared video/system RAM (1-cycle read BRAM).
// Video has absolute priority; CPU and loader share the leftover slots.
// Optional macro VRAM_STARVE_GUARD_EN: a CPU kept waiting MAX_WAIT cycles
// steals one slot from the video (flagged on vid_miss).
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int            AW       = AW_DEF,
    parameter int            DW       = DW_DEF,
    parameter logic [AW-1:0] ROM_BASE = AW'(ROM_BASE_DEF),
    parameter logic [AW-1:0] ROM_TOP  = AW'(ROM_TOP_DEF),
    parameter int            MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    output logic          vid_miss,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          ldr_req,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic          w_guard;
    logic          w_vid_gnt;
    logic          w_cpu_gnt;
    logic          w_ldr_gnt;
    logic          w_rr_en;
    logic [1:0]    w_rr_gnt;
    logic          w_cpu_rom;
    logic [AW-1:0] r_mem_addr;
    owner_t        r_owner_q;
    owner_t        r_rr_last;

`ifdef VRAM_STARVE_GUARD_EN
    localparam int WCW = (MAX_WAIT > 15) ? $clog2(MAX_WAIT + 1) : 4;
    logic [WCW-1:0] r_wait_cnt;

    // Count consecutive cycles the CPU is left waiting; saturate at threshold
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_wait_cnt <= '0;
        else if (cpu_req && !cpu_ack) begin
            if (r_wait_cnt != WCW'(MAX_WAIT))
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end else
            r_wait_cnt <= '0;
    end

    assign w_guard = !reset && cpu_req && (r_wait_cnt == WCW'(MAX_WAIT));
`else
    assign w_guard = 1'b0;
`endif

    // Grants are suppressed while reset is high so every output sits at its reset value
    assign w_vid_gnt = !reset && vid_req && !w_guard;
    assign w_rr_en   = !reset && !vid_req && !w_guard;

    vram_rr_pick u_rr (
        .req  ({ldr_req, cpu_req}),
        .last (r_rr_last == OWN_LDR),
        .en   (w_rr_en),
        .gnt  (w_rr_gnt)
    );

    assign w_cpu_gnt = w_guard | w_rr_gnt[0];
    assign w_ldr_gnt = w_rr_gnt[1];
    assign w_cpu_rom = (cpu_addr >= ROM_BASE) && (cpu_addr <= ROM_TOP);

    assign cpu_ack  = w_cpu_gnt;
    assign ldr_ack  = w_ldr_gnt;
    assign vid_miss = w_guard & vid_req;

    // Steer the RAM port to the granted requester; idle slots hold the last address
    always_comb begin
        mem_addr  = r_mem_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (w_vid_gnt) begin
            mem_addr = vid_addr;
        end else if (w_cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we && !w_cpu_rom;
            mem_wdata = cpu_wdata;
        end else if (w_ldr_gnt) begin
            mem_addr  = ldr_addr;
            mem_we    = 1'b1;
            mem_wdata = ldr_wdata;
        end
    end

    // Address hold, read-return owner and round-robin history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_addr <= '0;
            r_owner_q  <= OWN_NONE;
            r_rr_last  <= OWN_LDR;
        end else begin
            r_mem_addr <= mem_addr;
            if (w_vid_gnt)
                r_owner_q <= OWN_VID;
            else if (w_cpu_gnt && !cpu_we)
                r_owner_q <= OWN_CPU;
            else
                r_owner_q <= OWN_NONE;
            if (w_cpu_gnt)
                r_rr_last <= OWN_CPU;
            else if (w_ldr_gnt)
                r_rr_last <= OWN_LDR;
        end
    end

    assign vid_valid  = (r_owner_q == OWN_VID);
    assign cpu_rvalid = (r_owner_q == OWN_CPU);
    assign vid_data   = mem_rdata;
    assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter with a behavioural sync BRAM.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic [7:0]  vid_data;
    logic        vid_valid, vid_miss;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_rvalid;
    logic        ldr_req;
    logic [15:0] ldr_addr;
    logic [7:0]  ldr_wdata;
    logic        ldr_ack;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [7:0]  ram     [0:65535];
    logic [7:0]  exp_mem [0:65535];
    logic [7:0]  cpu_q[$];
    logic [7:0]  vid_q[$];
    int checks   = 0;
    int failures = 0;
    int j;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_valid(vid_valid), .vid_miss(vid_miss),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Sync BRAM, read-before-write, one cycle read latency
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] <= init_val(16'(i));
        ram[16'h1000] <= 8'hA5;
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: pop an expected read value on every return
    always @(negedge clk) begin
        if (cpu_rvalid === 1'b1) begin
            chk("cpu_rv_pending", 32'(cpu_q.size() > 0), 1);
            if (cpu_q.size() > 0) chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
        end
        if (vid_valid === 1'b1) begin
            chk("vid_rv_pending", 32'(vid_q.size() > 0), 1);
            if (vid_q.size() > 0) chk("vid_data", vid_data, vid_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic [15:0] a, input int exp_wait);
        int n = 0;
        logic got;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        @(negedge clk);
        while (cpu_ack !== 1'b1 && n < 40) begin
            tick();
            @(negedge clk);
            n++;
        end
        got = (cpu_ack === 1'b1);
        chk("cpu_rd_ack", got, 1);
        chk("cpu_rd_wait", n, exp_wait);
        if (got) cpu_q.push_back(exp_mem[a]);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("cpu_rd_rvalid", cpu_rvalid, got);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic exp_we);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
        chk("cpu_wr_ack", cpu_ack, 1);
        chk("cpu_wr_we", mem_we, exp_we);
        if (exp_we) exp_mem[a] = d;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        chk("cpu_wr_norv", cpu_rvalid, 0);
    endtask

    task automatic ldr_write(input logic [15:0] a, input logic [7:0] d);
        tick();
        ldr_req = 1'b1; ldr_addr = a; ldr_wdata = d;
        @(negedge clk);
        chk("ldr_wr_ack", ldr_ack, 1);
        chk("ldr_wr_we", mem_we, 1);
        chk("ldr_wr_addr", mem_addr, a);
        chk("ldr_wr_data", mem_wdata, d);
        exp_mem[a] = d;
        tick();
        ldr_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) exp_mem[i] = init_val(16'(i));
        exp_mem[16'h1000] = 8'hA5;

        // Reset with every requester active: all outputs must stay quiet
        reset = 1'b1;
        vid_req = 1'b1; vid_addr = 16'h0123;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0042; cpu_wdata = 8'h77;
        ldr_req = 1'b1; ldr_addr = 16'h0044; ldr_wdata = 8'h66;
        @(negedge clk);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_ldr_ack", ldr_ack, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_vid_valid", vid_valid, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_vid_miss", vid_miss, 0);
        chk("rst_mem_addr", mem_addr, 0);
        tick();
        reset = 1'b0; vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; ldr_req = 1'b0;
        @(negedge clk);

        // Basic CPU read, ack in the request cycle
        cpu_read(16'h1000, 0);

        // Video holds the port; CPU waits until video drops
        tick();
        vid_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000;
        for (int i = 0; i < 5; i++) begin
            vid_addr = 16'(16'h0200 + i);
            @(negedge clk);
            chk("vp_cpu_ack", cpu_ack, 0);
            chk("vp_vid_miss", vid_miss, 0);
            chk("vp_mem_addr", mem_addr, vid_addr);
            if (i > 0) chk("vp_vid_valid", vid_valid, 1);
            vid_q.push_back(exp_mem[vid_addr]);
            tick();
        end
        vid_req = 1'b0;
        @(negedge clk);
        chk("vp_cpu_ack_after", cpu_ack, 1);
        chk("vp_vid_valid_last", vid_valid, 1);
        cpu_q.push_back(exp_mem[16'h2000]);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("vp_cpu_rvalid", cpu_rvalid, 1);
        chk("vp_vid_valid_off", vid_valid, 0);

        // Reset the cycle after a CPU read ack: the return is discarded
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1000;
        @(negedge clk);
        chk("mr_cpu_ack", cpu_ack, 1);
        tick();
        reset = 1'b1; ldr_req = 1'b1;
        @(negedge clk);
        chk("mr_cpu_rvalid", cpu_rvalid, 0);
        chk("mr_cpu_ack", cpu_ack, 0);
        chk("mr_ldr_ack", ldr_ack, 0);
        chk("mr_mem_we", mem_we, 0);
        chk("mr_mem_addr", mem_addr, 0);
        tick();
        reset = 1'b0;

        // CPU and loader both held: strict alternation, CPU first after reset
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1000;
        ldr_req = 1'b1; j = 0; ldr_addr = 16'h3000; ldr_wdata = 8'hC0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_cpu", cpu_ack, 32'((k % 2) == 0));
            chk("rr_ldr", ldr_ack, 32'((k % 2) == 1));
            if ((k % 2) == 0) cpu_q.push_back(exp_mem[16'h1000]);
            else begin
                exp_mem[ldr_addr] = ldr_wdata;
                j++;
            end
            tick();
            ldr_addr = 16'(16'h3000 + j);
            ldr_wdata = 8'(8'hC0 + j);
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        @(negedge clk);
        cpu_read(16'h3001, 0);
        cpu_read(16'h3003, 0);

        // Write protect and region boundaries
        cpu_write(16'h8010, 8'h3C, 1'b0);
        cpu_read(16'h8010, 0);
        ldr_write(16'h8010, 8'h3C);
        cpu_read(16'h8010, 0);
        cpu_write(16'h8000, 8'h22, 1'b0);
        cpu_write(16'h8FFF, 8'h11, 1'b0);
        cpu_write(16'h7FFF, 8'h33, 1'b1);
        cpu_write(16'h9000, 8'h44, 1'b1);
        cpu_read(16'h8000, 0);
        cpu_read(16'h8FFF, 0);
        cpu_read(16'h7FFF, 0);
        cpu_read(16'h9000, 0);

        // Constant video traffic against a waiting CPU
        tick();
        vid_req = 1'b1; vid_addr = 16'h0300;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1000;
`ifdef VRAM_STARVE_GUARD_EN
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k < 15) begin
                chk("sg_cpu_wait", cpu_ack, 0);
                chk("sg_no_miss", vid_miss, 0);
                vid_q.push_back(exp_mem[16'h0300]);
                tick();
            end else begin
                chk("sg_cpu_ack", cpu_ack, 1);
                chk("sg_vid_miss", vid_miss, 1);
                chk("sg_mem_addr", mem_addr, 16'h1000);
                cpu_q.push_back(exp_mem[16'h1000]);
            end
        end
        tick();
        cpu_req = 1'b0; vid_req = 1'b0;
        @(negedge clk);
        chk("sg_vid_valid", vid_valid, 0);
        chk("sg_cpu_rvalid", cpu_rvalid, 1);
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("ng_cpu_wait", cpu_ack, 0);
            chk("ng_no_miss", vid_miss, 0);
            vid_q.push_back(exp_mem[16'h0300]);
            tick();
        end
        vid_req = 1'b0;
        @(negedge clk);
        chk("ng_cpu_ack", cpu_ack, 1);
        cpu_q.push_back(exp_mem[16'h1000]);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("ng_cpu_rvalid", cpu_rvalid, 1);
`endif

        tick();
        tick();
        @(negedge clk);
        chk("cpu_q_empty", cpu_q.size(), 0);
        chk("vid_q_empty", vid_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
